// File: rtl/spec_branch_tracker.sv
// Speculative branch tracker: in-order tag allocation, in-order retire on resolve,
// and squash of younger branches on mispredict with one retire pulse per squashed entry.
module spec_branch_tracker #(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid_i,
  output logic             br_ready_o,
  output logic [TAG_W-1:0] br_tag_o,
  input  logic             res_valid_i,
  input  logic [TAG_W-1:0] res_tag_i,
  input  logic             res_mispredict_i,
  output logic             fence_o,
  output logic             retire_branch_o,
  output logic             flush_o,
  output logic [TAG_W:0]   count_o
);

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TAG_W:0]   r_head;
  logic [TAG_W:0]   r_tail;
  logic [TAG_W:0]   r_drain_cnt;
  logic [DEPTH-1:0] r_resolved;
  logic             r_fence;
  logic             r_retire;
  logic             r_flush;

  logic [TAG_W:0]   w_count;
  logic [TAG_W-1:0] w_offset;
  logic             w_mis_req;
  logic             w_push;
  logic             w_res_apply;
  logic             w_mis_apply;
  logic             w_retire;
  logic             w_drain_pulse;
  logic [TAG_W:0]   w_n_young;
  logic [TAG_W:0]   w_mis_tail;
  logic [TAG_W:0]   w_drain_nxt;

  always_comb begin
    w_count       = r_tail - r_head;
    w_offset      = res_tag_i - r_head[TAG_W-1:0];
    w_mis_req     = res_valid_i && res_mispredict_i;
    br_ready_o    = (r_state == ST_RUN) && (w_count < (TAG_W+1)'(DEPTH)) && !w_mis_req && !rst;
    br_tag_o      = r_tail[TAG_W-1:0];
    w_push        = br_valid_i && br_ready_o;
    w_res_apply   = res_valid_i && ({1'b0, w_offset} < w_count) && !r_resolved[res_tag_i];
    w_mis_apply   = w_res_apply && res_mispredict_i;
    w_retire      = (r_state == ST_RUN) && (w_count != '0) && r_resolved[r_head[TAG_W-1:0]];
    w_drain_pulse = (r_state == ST_DRAIN);
    w_n_young     = w_count - {1'b0, w_offset} - (TAG_W+1)'(1);
    // Squash point is measured from the pre-retire head, so a same-edge retire still lands correctly.
    w_mis_tail    = r_head + {1'b0, w_offset} + (TAG_W+1)'(1);
    w_drain_nxt   = r_drain_cnt + (w_mis_apply ? w_n_young : '0)
                    - (TAG_W+1)'(w_drain_pulse);
    w_state_nxt   = (w_drain_nxt != '0) ? ST_DRAIN : ST_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_drain_cnt <= '0;
      r_resolved  <= '0;
      r_fence     <= 1'b0;
      r_retire    <= 1'b0;
      r_flush     <= 1'b0;
    end else begin
      r_drain_cnt <= w_drain_nxt;
      r_fence     <= w_push;
      r_retire    <= w_retire || w_drain_pulse;
      r_flush     <= w_mis_apply;
      if (w_push) begin
        r_resolved[r_tail[TAG_W-1:0]] <= 1'b0;
      end
      if (w_res_apply) begin
        r_resolved[res_tag_i] <= 1'b1;
      end
      if (w_mis_apply) begin
        r_tail <= w_mis_tail;
      end else if (w_push) begin
        r_tail <= r_tail + (TAG_W+1)'(1);
      end
      if (w_retire) begin
        r_head <= r_head + (TAG_W+1)'(1);
      end
    end
  end

  assign fence_o         = r_fence;
  assign retire_branch_o = r_retire;
  assign flush_o         = r_flush;
  assign count_o         = w_count;

endmodule

// File: tb/tb_spec_branch_tracker.sv
// Randomized bench for spec_branch_tracker against a queue-based program-order model.
module tb_spec_branch_tracker;

  localparam int DEPTH = 8;
  localparam int TAG_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             br_valid_i = 1'b0;
  logic             br_ready_o;
  logic [TAG_W-1:0] br_tag_o;
  logic             res_valid_i = 1'b0;
  logic [TAG_W-1:0] res_tag_i = '0;
  logic             res_mispredict_i = 1'b0;
  logic             fence_o;
  logic             retire_branch_o;
  logic             flush_o;
  logic [TAG_W:0]   count_o;

  spec_branch_tracker #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .br_valid_i       (br_valid_i),
    .br_ready_o       (br_ready_o),
    .br_tag_o         (br_tag_o),
    .res_valid_i      (res_valid_i),
    .res_tag_i        (res_tag_i),
    .res_mispredict_i (res_mispredict_i),
    .fence_o          (fence_o),
    .retire_branch_o  (retire_branch_o),
    .flush_o          (flush_o),
    .count_o          (count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: live branches in program order (resolved flag each), tag of the oldest,
  // and squash pulses still owed.
  bit q[$];
  int head_tag = 0;
  int drain    = 0;
  int obs_fence = 0;
  int obs_ret   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    head_tag  = 0;
    drain     = 0;
    obs_fence = 0;
    obs_ret   = 0;
  endtask

  task automatic step(input bit v, input int t, input bit m, input bit r);
    bit exp_ready, retire, dpulse, push, apply;
    int off, n;
    logic [31:0] tv;
    tv = t;
    @(negedge clk);
    br_valid_i       = v;
    res_tag_i        = tv[TAG_W-1:0];
    res_mispredict_i = m;
    res_valid_i      = r;
    #1;
    exp_ready = (drain == 0) && (q.size() < DEPTH) && !(r && m);
    check("br_ready", int'(br_ready_o), int'(exp_ready));
    check("br_tag", int'(br_tag_o), (head_tag + q.size()) % DEPTH);
    retire = (drain == 0) && (q.size() > 0) && q[0];
    dpulse = (drain != 0);
    push   = v && exp_ready;
    off    = (int'(tv[TAG_W-1:0]) - head_tag + DEPTH) % DEPTH;
    apply  = r && (off < q.size()) && !q[off];
    @(posedge clk);
    if (apply) begin
      q[off] = 1'b1;
      if (m) begin
        n = q.size() - off - 1;
        repeat (n) void'(q.pop_back());
        drain += n;
      end
    end
    if (retire) begin
      void'(q.pop_front());
      head_tag = (head_tag + 1) % DEPTH;
    end
    if (dpulse) drain--;
    if (push) q.push_back(1'b0);
    #1;
    check("fence", int'(fence_o), int'(push));
    check("retire", int'(retire_branch_o), int'(retire || dpulse));
    check("flush", int'(flush_o), int'(apply && m));
    check("count", int'(count_o), q.size());
    obs_fence += int'(fence_o);
    obs_ret   += int'(retire_branch_o);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    br_valid_i = 1'b0; res_valid_i = 1'b0; res_mispredict_i = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_ready", int'(br_ready_o), 0);
    check("rst_fence", int'(fence_o), 0);
    check("rst_retire", int'(retire_branch_o), 0);
    check("rst_flush", int'(flush_o), 0);
    check("rst_count", int'(count_o), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int t;
    bit v, r, m;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("por_count", int'(count_o), 0);
    check("por_ready", int'(br_ready_o), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic flow
    step(1, 0, 0, 0); idle(2); step(0, 0, 0, 1); idle(3);
    check("basic_count", int'(count_o), 0);

    // Out-of-order resolve
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 2, 0, 1); step(0, 1, 0, 1); step(0, 0, 0, 1); idle(4);

    // Full, retire 3, refill with wrapped tags, unallocated resolve ignored
    do_reset();
    repeat (DEPTH) step(1, 0, 0, 0);
    check("full_count", int'(count_o), DEPTH);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1); step(0, 1, 0, 1); step(0, 2, 0, 1); idle(4);
    repeat (3) step(1, 0, 0, 0);
    check("wrap_count", int'(count_o), DEPTH);
    do_reset();
    step(1, 0, 0, 0); step(0, 5, 1, 1); idle(2);

    // Mispredict squash, then youngest mispredict, then nested mispredict in drain
    do_reset();
    repeat (6) step(1, 0, 0, 0);
    step(0, 2, 1, 1); idle(5);
    check("squash_count", int'(count_o), 3);
    check("squash_tag", int'(br_tag_o), 3);
    step(0, 0, 0, 1); step(0, 1, 0, 1); idle(4);
    check("squash_bal", obs_fence, obs_ret);
    repeat (4) step(1, 0, 0, 0);
    step(0, 6, 1, 1); idle(2);
    step(0, 4, 1, 1); idle(1); step(0, 3, 1, 1); idle(6);

    // Reset mid-drain
    do_reset();
    repeat (7) step(1, 0, 0, 0);
    step(0, 0, 1, 1); idle(2);
    do_reset();
    step(1, 0, 0, 0); idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) == 0);
      m = ($urandom_range(0, 6) == 0);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        t = (head_tag + $urandom_range(0, q.size() - 1)) % DEPTH;
      else
        t = $urandom_range(0, DEPTH - 1);
      step(v, t, m, r);
    end
    idle(DEPTH + 2);
    check("invariant", obs_fence, obs_ret + int'(count_o) + drain);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
